// File: rtl/seu_monitor_pkg.sv
// Shared types and constants for the SEU chain monitor.
package seu_monitor_pkg;

  // Run-control FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_CHECK = 2'd2
  } state_e;

  // Test pattern encoding as presented on pattern_sel
  typedef enum logic [1:0] {
    PAT_ZEROS = 2'd0,
    PAT_ONES  = 2'd1,
    PAT_ALT   = 2'd2,
    PAT_LFSR  = 2'd3
  } pat_e;

  localparam int unsigned LFSR_W = 16;

  // Seed reloaded on every accepted start and on reset
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;

  // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR land on bits 0,2,3,5
  localparam logic [LFSR_W-1:0] LFSR_TAP_MASK = 16'h002D;

  // One LFSR step: feedback enters at the MSB, output bit is the LSB
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {^(s & LFSR_TAP_MASK), s[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/seu_monitor_lfsr.sv
// 16-bit Fibonacci LFSR pattern source with seed load and step enable.
module seu_monitor_lfsr
  import seu_monitor_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  output logic [LFSR_W-1:0] value
);

  // Seed load wins over advance so a restart always begins at the seed
  always_ff @(posedge clk) begin
    if (rst || load) begin
      value <= LFSR_SEED;
    end else if (advance) begin
      value <= lfsr_step(value);
    end
  end

endmodule

// File: rtl/seu_monitor.sv
// Drives a test pattern into an external hardened flop chain and counts
// mismatches between the returned data and a delayed copy of what was sent.
module seu_monitor
  import seu_monitor_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 8,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       pattern_sel,
  output logic             dut_d,
  input  logic             dut_q,
  output logic             busy,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_sat,
  output logic             err_flag
);

  localparam int unsigned     FILL_W    = $clog2(CHAIN_LEN);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_e                state;
  state_e                state_next;
  pat_e                  pat;
  logic [FILL_W-1:0]     fill_cnt;
  logic [CHAIN_LEN-1:0]  dline;
  logic [LFSR_W-1:0]     lfsr_val;
  logic [LFSR_W-1:0]     lfsr_nxt;
  logic                  start_acc;
  logic                  lfsr_load;
  logic                  lfsr_adv;
  logic                  cmp_en;
  logic                  mismatch;
  logic                  dut_d_next;
  logic                  busy_next;

  assign lfsr_nxt = lfsr_step(lfsr_val);
  assign mismatch = dut_q ^ dline[CHAIN_LEN-1];

  seu_monitor_lfsr u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (lfsr_load),
    .advance (lfsr_adv),
    .value   (lfsr_val)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: stop beats the FILL-to-CHECK step, start only counts in IDLE
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_FILL;
      end
      ST_FILL: begin
        if (stop)                       state_next = ST_IDLE;
        else if (fill_cnt == FILL_LAST) state_next = ST_CHECK;
      end
      ST_CHECK: begin
        if (stop) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Control decode and next pattern bit for the cycle after this edge
  always_comb begin
    start_acc  = (state == ST_IDLE) && start;
    lfsr_load  = start_acc;
    lfsr_adv   = (state != ST_IDLE);
    cmp_en     = (state == ST_CHECK);
    busy_next  = (state_next != ST_IDLE);
    dut_d_next = 1'b0;
    if (start_acc) begin
      case (pat_e'(pattern_sel))
        PAT_ZEROS: dut_d_next = 1'b0;
        PAT_ONES:  dut_d_next = 1'b1;
        PAT_ALT:   dut_d_next = 1'b0;
        PAT_LFSR:  dut_d_next = LFSR_SEED[0];
        default:   dut_d_next = 1'b0;
      endcase
    end else if (busy_next) begin
      case (pat)
        PAT_ZEROS: dut_d_next = 1'b0;
        PAT_ONES:  dut_d_next = 1'b1;
        PAT_ALT:   dut_d_next = ~dut_d;
        PAT_LFSR:  dut_d_next = lfsr_nxt[0];
        default:   dut_d_next = 1'b0;
      endcase
    end
  end

  // Counts cycles spent in FILL
  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      fill_cnt <= '0;
    end else if (state == ST_FILL) begin
      fill_cnt <= fill_cnt + FILL_W'(1);
    end
  end

  // Pattern choice is frozen for the whole run
  always_ff @(posedge clk) begin
    if (rst) begin
      pat <= PAT_ZEROS;
    end else if (start_acc) begin
      pat <= pat_e'(pattern_sel);
    end
  end

  // Registered pattern output and busy indication
  always_ff @(posedge clk) begin
    if (rst) begin
      dut_d <= 1'b0;
      busy  <= 1'b0;
    end else begin
      dut_d <= dut_d_next;
      busy  <= busy_next;
    end
  end

  // Expected-data delay line mirroring the external chain depth
  always_ff @(posedge clk) begin
    if (rst) begin
      dline <= '0;
    end else begin
      dline <= {dline[CHAIN_LEN-2:0], dut_d};
    end
  end

  // Saturating mismatch counter with sticky flags, cleared by a new run
  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      err_cnt  <= '0;
      err_sat  <= 1'b0;
      err_flag <= 1'b0;
    end else if (cmp_en && mismatch) begin
      err_flag <= 1'b1;
      if (err_cnt != CNT_MAX) begin
        err_cnt <= err_cnt + CNT_W'(1);
        if (err_cnt == CNT_MAX - CNT_W'(1)) err_sat <= 1'b1;
      end
    end
  end

endmodule

// File: doc/seu_monitor.md
SEU_MONITOR -- requirements
Module: seu_monitor

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 8, meaning the number of hardened flops in the external chain under test (range 2..64).
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the error counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: pulse that begins a run.
REQ-006 SHALL have port stop, input, 1 bit: pulse that ends a run.
REQ-007 SHALL have port pattern_sel, input, 2 bits: 0 all-zeros, 1 all-ones, 2 alternating, 3 LFSR.
REQ-008 SHALL have port dut_d, output, 1 bit: serial data driven into the chain under test.
REQ-009 SHALL have port dut_q, input, 1 bit: serial data returned from the chain end.
REQ-010 SHALL have port busy, output, 1 bit: high in FILL or CHECK.
REQ-011 SHALL have port err_cnt, output, CNT_W bits: mismatch count.
REQ-012 SHALL have port err_sat, output, 1 bit: err_cnt has saturated.
REQ-013 SHALL have port err_flag, output, 1 bit: sticky, set by any mismatch in the current or last run.

Function
REQ-014 SHALL implement the FSM states IDLE, FILL and CHECK.
REQ-015 SHALL go from IDLE to FILL on start; start SHALL be ignored in FILL and CHECK.
REQ-016 SHALL stay in FILL for exactly CHAIN_LEN cycles, then enter CHECK.
REQ-017 SHALL go from FILL or CHECK to IDLE on stop; stop SHALL have priority over the FILL-to-CHECK transition; stop in IDLE SHALL have no effect.
REQ-018 SHALL, when start and stop are high together in IDLE, enter FILL.
REQ-019 SHALL latch pattern_sel on start; changes to pattern_sel during a run SHALL be ignored.
REQ-020 SHALL drive the pattern on dut_d each cycle in FILL/CHECK, starting with the first FILL cycle: alternating = 0,1,0,1...; LFSR = LSB of a 16-bit Fibonacci LFSR with taps 16,14,13,11 and seed 16'hACE1, reloaded on start, advancing once per busy cycle.
REQ-021 SHALL drive dut_d to 0 in IDLE.
REQ-022 SHALL hold an internal CHAIN_LEN-deep expected-data delay line of driven dut_d bits; the expected bit for a cycle SHALL be the dut_d value driven CHAIN_LEN cycles earlier.
REQ-023 SHALL, in CHECK only, compare dut_q against the expected bit every cycle; mismatch SHALL increment err_cnt and set err_flag on the next clock edge.
REQ-024 SHALL saturate err_cnt at 2^CNT_W-1 without wrap, and set err_sat when it reaches that value.
REQ-025 SHALL clear err_cnt, err_sat and err_flag on accepted start; SHALL hold them unchanged in IDLE.
REQ-026 SHALL not compare in FILL or IDLE; the cycle stop is sampled in CHECK SHALL still be compared.

Reset
REQ-027 SHALL, on rst high at a clock edge, go to IDLE, set dut_d=0, busy=0, err_cnt=0, err_sat=0, err_flag=0, clear the delay line and load the LFSR with seed.
REQ-028 SHALL have rst take priority over start/stop, and rst mid-run SHALL abort the run with no further counting.

Structure
REQ-029 SHALL place the state enum, the pattern_sel encoding enum, LFSR seed and tap constants in package seu_monitor_pkg.
REQ-030 SHALL implement the LFSR as sub-module seu_monitor_lfsr with load and advance inputs; all other logic SHALL be in seu_monitor.

Verification
REQ-031 SHALL cover: CHAIN_LEN=8, bench model is an 8-flop delay, pattern 3, start, run 100 cycles -> busy after 1 cycle, CHECK at cycle 8, err_cnt=0, err_flag=0.
REQ-032 SHALL cover: pattern 2 with a single bench bit-flip injected at dut_q in CHECK -> err_cnt=1, err_flag=1; after stop, values held.
REQ-033 SHALL cover: CNT_W=4, dut_q forced inverted, pattern 1, 20 CHECK cycles -> err_cnt=15, err_sat=1, no wrap.
REQ-034 SHALL cover: a flip injected during FILL only -> err_cnt=0.
REQ-035 SHALL cover: start+stop together in IDLE -> FILL entered; stop on the last FILL cycle -> IDLE, CHECK never entered.
REQ-036 SHALL cover: rst asserted mid-CHECK with err_cnt=3 -> next cycle all outputs 0; new start produces a first LFSR bit equal to LSB of 16'hACE1 (1).
